// File: rtl/ex_muldiv_unit.sv
// Execute-stage HI/LO unit: iterative multiply/divide running in the
// background, owner of the HI/LO registers, MFHI/MFLO/MTHI/MTLO service
// and the stall request toward hazard control.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_reg;
    logic [CW-1:0]        count_reg;
    logic [WIDTH-1:0]     b_reg;        // multiplicand or divisor (magnitude)
    logic [2*WIDTH-1:0]   acc_reg;      // {upper, lower}: product or {rem, quot}
    logic                 is_div_reg;
    logic                 neg_a_reg;
    logic                 neg_b_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;

    // Instruction decode (R-type only)
    logic is_r, dec_mul, dec_div, dec_signed, dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;
    assign is_r       = valid && (opcode == 6'h00);
    assign dec_mul    = is_r && ((func == 6'h18) || (func == 6'h19));
    assign dec_div    = is_r && ((func == 6'h1A) || (func == 6'h1B));
    assign dec_signed = !func[0];
    assign dec_mfhi   = is_r && (func == 6'h10);
    assign dec_mflo   = is_r && (func == 6'h12);
    assign dec_mthi   = is_r && (func == 6'h11);
    assign dec_mtlo   = is_r && (func == 6'h13);

    // Operand magnitudes; unsigned ops pass through untouched
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    assign a_neg = dec_signed && opA[WIDTH-1];
    assign b_neg = dec_signed && opB[WIDTH-1];
    assign a_abs = a_neg ? (~opA + 1'b1) : opA;
    assign b_abs = b_neg ? (~opB + 1'b1) : opB;

    // Shift-add multiply step: add multiplicand when the current multiplier bit is set
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign mul_addend[gi] = b_reg[gi] & acc_reg[0];
        end
    endgenerate
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide step: shift in the next dividend bit, subtract if it fits
    logic [WIDTH:0]     div_sh;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_sh   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff = {1'b0, div_sh} - {2'b00, b_reg};
    assign div_next = div_diff[WIDTH+1] ? {div_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

    // Sign correction; a zero divisor naturally leaves the raw dividend in the remainder
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    assign prod_fix = (neg_a_reg ^ neg_b_reg) ? (~acc_reg + 1'b1) : acc_reg;
    assign quot_fix = (b_reg == '0) ? '1 :
                      ((neg_a_reg ^ neg_b_reg) ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0]);
    assign rem_fix  = neg_a_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1) : acc_reg[2*WIDTH-1:WIDTH];

    // FSM, iteration datapath and HI/LO ownership
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            b_reg      <= '0;
            acc_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_a_reg  <= 1'b0;
            neg_b_reg  <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (dec_mul || dec_div) begin
                        state_reg  <= RUN;
                        count_reg  <= '0;
                        b_reg      <= b_abs;
                        acc_reg    <= {{WIDTH{1'b0}}, a_abs};
                        is_div_reg <= dec_div;
                        neg_a_reg  <= a_neg;
                        neg_b_reg  <= b_neg;
                    end
                    if (dec_mthi) hi_reg <= opA;
                    if (dec_mtlo) lo_reg <= opA;
                end
                RUN: begin
                    acc_reg   <= is_div_reg ? div_next : mul_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CW'(ITER - 1)) state_reg <= FIX;
                end
                FIX: begin
                    state_reg <= IDLE;
                    if (is_div_reg) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quot_fix;
                    end else begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy   = (state_reg != IDLE);
    assign hi     = hi_reg;
    assign lo     = lo_reg;
    assign stall  = busy && (dec_mul || dec_div || dec_mfhi || dec_mflo || dec_mthi || dec_mtlo);
    assign result = dec_mfhi ? hi_reg : (dec_mflo ? lo_reg : '0);

endmodule
